// File: rtl/tune_pkg.sv
// Shared constants for the tune decoder: melody IDs, the signature ROM
// and the per-melody note-code ranges.
package tune_pkg;

  localparam int NOTE_W = 5;

  typedef logic [NOTE_W-1:0] code_t;

  localparam logic [1:0] TUNE_TWINKLE = 2'd0;
  localparam logic [1:0] TUNE_ASC     = 2'd1;
  localparam logic [1:0] TUNE_DESC    = 2'd2;

  localparam code_t SIG [3][7] = '{
    '{5'd8,  5'd8,  5'd12, 5'd12, 5'd13, 5'd13, 5'd12},
    '{5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7},
    '{5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd16, 5'd15}
  };

  localparam code_t CODE_MIN [3] = '{5'd8,  5'd1, 5'd15};
  localparam code_t CODE_MAX [3] = '{5'd13, 5'd7, 5'd21};

  function automatic code_t sig_code(input logic [1:0] m,
                                     input logic [2:0] i);
    code_t r;
    r = '0;
    if (m != 2'd3 && i != 3'd7) r = SIG[m][i];
    return r;
  endfunction

  function automatic logic in_range(input logic [1:0] m,
                                    input code_t c);
    logic r;
    r = 1'b0;
    if (m != 2'd3) r = (c >= CODE_MIN[m]) && (c <= CODE_MAX[m]);
    return r;
  endfunction

endpackage

// File: rtl/tune_sig_matcher.sv
// Tracks how far the onset stream has progressed through one melody's
// signature; a clear restarts it from zero in the same tick.
module tune_sig_matcher
  import tune_pkg::*;
#(
  parameter logic [1:0] MELODY = TUNE_TWINKLE,
  parameter int         LEN    = 7
) (
  input  logic       clk16Hz,
  input  logic       rst,
  input  logic       i_onset,
  input  code_t      i_code,
  input  logic       i_freeze,
  input  logic       i_clear,
  output logic [2:0] o_idx,
  output logic       o_done
);

  localparam logic [2:0] LAST = 3'(LEN - 1);

  logic [2:0] r_idx;
  logic [2:0] w_base;
  logic [2:0] w_nxt;
  code_t      w_exp;
  logic       w_step;
  logic       w_hit;

  always_comb begin
    w_base = i_clear ? 3'd0 : r_idx;
    w_exp  = sig_code(MELODY, w_base);
    w_step = i_onset && !i_freeze;
    w_hit  = (i_code == w_exp);
    w_nxt  = w_base;
    if (w_step) begin
      if (w_hit)
        w_nxt = w_base + 3'd1;
      else if (i_code == sig_code(MELODY, 3'd0))
        w_nxt = 3'd1;
      else
        w_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk16Hz or posedge rst) begin
    if (rst) r_idx <= 3'd0;
    else     r_idx <= w_nxt;
  end

  assign o_idx  = r_idx;
  assign o_done = w_step && w_hit && (w_base == LAST);

endmodule

// File: rtl/tune_decoder.sv
// Identifies which melody the sequencer is playing from its 16 Hz
// note-code stream and reports a locked melody ID.
module tune_decoder
  import tune_pkg::*;
#(
  parameter int SILENCE = 24,
  parameter int SIG_LEN = 7
) (
  input  logic        clk16Hz,
  input  logic        rst,
  input  logic        en,
  input  logic [4:0]  tune,
  output logic        id_valid,
  output logic [1:0]  tune_id,
  output logic        onset,
  output logic [4:0]  note,
  output logic        silent
);

  localparam logic [4:0] SIL = 5'(SILENCE);

  code_t      r_prev;
  logic [4:0] r_cnt;
  logic [1:0] r_tune_id;
  logic       r_onset;
  code_t      r_note;
  logic       r_silent;

  logic       w_onset;
  logic [4:0] w_cnt_nxt;
  logic       w_sil_hit;
  logic       w_lock;
  logic       w_oor;
  logic       w_freeze;
  logic       w_clear;
  logic       w_m_onset;
  logic [2:0] w_done;
  logic [2:0] w_idx [3];
  logic [1:0] w_hit_id;

  always_comb begin
    w_onset   = (tune != '0) && (tune != r_prev);
    w_cnt_nxt = '0;
    if (tune == '0)
      w_cnt_nxt = (r_cnt >= SIL) ? SIL : r_cnt + 5'd1;
    w_sil_hit = (w_cnt_nxt == SIL);
    w_lock    = (w_idx[0] == 3'd7) || (w_idx[1] == 3'd7)
             || (w_idx[2] == 3'd7);
    // Leaving the locked melody's range restarts matching on this onset.
    w_oor     = w_lock && w_onset && !in_range(r_tune_id, tune);
    w_freeze  = w_lock && !w_oor;
    w_clear   = !en || w_sil_hit || w_oor;
    w_m_onset = en && w_onset;
    w_hit_id  = TUNE_TWINKLE;
    if (w_done[1]) w_hit_id = TUNE_ASC;
    if (w_done[2]) w_hit_id = TUNE_DESC;
  end

  for (genvar g = 0; g < 3; g++) begin : g_match
    tune_sig_matcher #(
      .MELODY (2'(g)),
      .LEN    (SIG_LEN)
    ) u_match (
      .clk16Hz  (clk16Hz),
      .rst      (rst),
      .i_onset  (w_m_onset),
      .i_code   (tune),
      .i_freeze (w_freeze),
      .i_clear  (w_clear),
      .o_idx    (w_idx[g]),
      .o_done   (w_done[g])
    );
  end

  always_ff @(posedge clk16Hz or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_cnt     <= SIL;
      r_tune_id <= TUNE_TWINKLE;
      r_onset   <= 1'b0;
      r_note    <= '0;
      r_silent  <= 1'b1;
    end else if (!en) begin
      r_prev    <= '0;
      r_cnt     <= SIL;
      r_tune_id <= TUNE_TWINKLE;
      r_onset   <= 1'b0;
      r_note    <= '0;
      r_silent  <= 1'b1;
    end else begin
      r_prev   <= tune;
      r_cnt    <= w_cnt_nxt;
      r_onset  <= w_onset;
      r_silent <= w_sil_hit;
      if (w_onset) r_note <= tune;
      if (|w_done) r_tune_id <= w_hit_id;
    end
  end

  assign id_valid = w_lock;
  assign tune_id  = r_tune_id;
  assign onset    = r_onset;
  assign note     = r_note;
  assign silent   = r_silent;

endmodule

// File: tb/tb_tune_decoder.sv
// Directed bench for tune_decoder: lock, relock, silence, partial
// match, reset and enable behaviour.
module tb_tune_decoder;

  logic       clk16Hz;
  logic       rst;
  logic       en;
  logic [4:0] tune;
  logic       id_valid;
  logic [1:0] tune_id;
  logic       onset;
  logic [4:0] note;
  logic       silent;

  int n_chk;
  int n_err;
  int n_on;

  tune_decoder dut (
    .clk16Hz  (clk16Hz),
    .rst      (rst),
    .en       (en),
    .tune     (tune),
    .id_valid (id_valid),
    .tune_id  (tune_id),
    .onset    (onset),
    .note     (note),
    .silent   (silent)
  );

  initial clk16Hz = 1'b0;
  always #5 clk16Hz = ~clk16Hz;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [4:0] c);
    tune = c;
    @(posedge clk16Hz);
    #1;
    n_on += int'(onset);
  endtask

  task automatic play(input logic [4:0] c, input int n);
    for (int i = 0; i < n; i++) tick(c);
  endtask

  logic [4:0] twk [14];

  initial begin
    twk = '{5'd8, 5'd8, 5'd12, 5'd12, 5'd13, 5'd13, 5'd12,
            5'd11, 5'd11, 5'd10, 5'd10, 5'd9, 5'd9, 5'd8};
    n_chk = 0;
    n_err = 0;
    n_on  = 0;
    rst   = 1'b1;
    en    = 1'b1;
    tune  = '0;
    #3;
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_id", 32'(tune_id), 0);
    chk("rst_onset", 32'(onset), 0);
    chk("rst_note", 32'(note), 0);
    chk("rst_silent", 32'(silent), 1);
    #10;
    rst = 1'b0;

    tick(5'd0);
    chk("idle_silent", 32'(silent), 1);
    n_on = 0;
    tick(5'd1);
    chk("asc1_onset", 32'(onset), 1);
    chk("asc1_note", 32'(note), 1);
    chk("asc1_silent", 32'(silent), 0);
    for (int c = 2; c <= 6; c++) tick(5'(c));
    chk("asc6_nolock", 32'(id_valid), 0);
    tick(5'd7);
    chk("asc_lock", 32'(id_valid), 1);
    chk("asc_id", 32'(tune_id), 1);
    chk("asc_note", 32'(note), 7);
    tick(5'd0);
    chk("asc_rest_onset", 32'(onset), 0);
    chk("asc_onsets", 32'(n_on), 7);

    play(5'd0, 22);
    chk("sil23_valid", 32'(id_valid), 1);
    chk("sil23_silent", 32'(silent), 0);
    tick(5'd3);
    chk("inrange_keep", 32'(id_valid), 1);
    chk("inrange_onset", 32'(onset), 1);
    play(5'd0, 23);
    chk("sil23b_valid", 32'(id_valid), 1);
    tick(5'd0);
    chk("sil24_valid", 32'(id_valid), 0);
    chk("sil24_silent", 32'(silent), 1);

    for (int c = 21; c >= 15; c--) tick(5'(c));
    chk("desc_lock", 32'(id_valid), 1);
    chk("desc_id", 32'(tune_id), 2);
    n_on = 0;
    tick(5'd1);
    chk("switch_drop", 32'(id_valid), 0);
    chk("switch_onset", 32'(onset), 1);
    chk("switch_note", 32'(note), 1);
    for (int c = 2; c <= 6; c++) tick(5'(c));
    chk("switch6_nolock", 32'(id_valid), 0);
    tick(5'd7);
    chk("relock_valid", 32'(id_valid), 1);
    chk("relock_id", 32'(tune_id), 1);
    chk("relock_onsets", 32'(n_on), 7);

    play(5'd0, 24);
    chk("unlock_pm", 32'(id_valid), 0);
    tick(5'd1);
    tick(5'd2);
    tick(5'd3);
    tick(5'd9);
    chk("pm9_valid", 32'(id_valid), 0);
    for (int c = 1; c <= 6; c++) tick(5'(c));
    chk("pm6_valid", 32'(id_valid), 0);
    tick(5'd7);
    chk("pm_lock", 32'(id_valid), 1);
    chk("pm_id", 32'(tune_id), 1);

    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(id_valid), 0);
    chk("arst_id", 32'(tune_id), 0);
    chk("arst_note", 32'(note), 0);
    chk("arst_onset", 32'(onset), 0);
    chk("arst_silent", 32'(silent), 1);
    tune = 5'd4;
    #2;
    rst = 1'b0;
    play(5'd0, 1);
    chk("arst_after_onset", 32'(onset), 0);
    for (int c = 1; c <= 7; c++) tick(5'(c));
    chk("prelock_en", 32'(id_valid), 1);
    en = 1'b0;
    tick(5'd5);
    chk("en_valid", 32'(id_valid), 0);
    chk("en_id", 32'(tune_id), 0);
    chk("en_onset", 32'(onset), 0);
    chk("en_note", 32'(note), 0);
    chk("en_silent", 32'(silent), 1);
    en = 1'b1;

    play(5'd0, 16);
    for (int k = 0; k < 6; k++) begin
      play(twk[k], 15);
      play(5'd0, 1);
    end
    chk("twk6_nolock", 32'(id_valid), 0);
    tick(5'd12);
    chk("twk_lock", 32'(id_valid), 1);
    chk("twk_id", 32'(tune_id), 0);
    chk("twk_note", 32'(note), 12);
    play(5'd12, 14);
    play(5'd0, 1);
    for (int k = 7; k < 14; k++) begin
      play(twk[k], 15);
      play(5'd0, 1);
    end
    chk("twk_tail_valid", 32'(id_valid), 1);
    play(5'd0, 16);
    chk("twk_rest_valid", 32'(id_valid), 1);
    chk("twk_rest_silent", 32'(silent), 0);
    tick(5'd8);
    chk("twk_next_valid", 32'(id_valid), 1);
    chk("twk_next_onset", 32'(onset), 1);
    chk("twk_next_note", 32'(note), 8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
